// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB requester arbiter.
package apb_arb_pkg;

  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state_e;

  // Width of the round-robin pointer; kept at least one bit for a single requester.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_arb_rr_pick.sv
// Combinational requester picker: round-robin from ptr when mode=1,
// lowest index first when mode=0.
module rr_pick
  import apb_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PTR_W = ptr_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             mode,
  output logic [N_REQ-1:0] winner,
  output logic             valid
);

  always_comb begin
    int start;
    int idx;
    winner = '0;
    start  = mode ? int'(ptr) : 0;
    // An out-of-range pointer falls back to index 0 rather than skipping requesters.
    if (start >= N_REQ) start = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = start + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx] && (winner == '0)) winner[idx] = 1'b1;
    end
  end

  assign valid = |req;

endmodule

// File: rtl/apb_arbiter.sv
// Shares one downstream APB initiator port between N_REQ APB requesters,
// re-issuing the winning transfer with its own SETUP/ACCESS phases.
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int ADDR_W      = 32,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        r_psel,
  input  logic [N_REQ-1:0]        r_penable,
  output logic [N_REQ-1:0]        r_pready,
  input  logic [N_REQ*ADDR_W-1:0] r_paddr,
  input  logic [N_REQ-1:0]        r_pwrite,
  input  logic [N_REQ*32-1:0]     r_pwdata,
  input  logic [N_REQ*4-1:0]      r_pwstrb,
  output logic [N_REQ*32-1:0]     r_prdata,
  output logic [N_REQ-1:0]        r_pslverr,
  output logic                    m_psel,
  output logic                    m_penable,
  input  logic                    m_pready,
  output logic [ADDR_W-1:0]       m_paddr,
  output logic                    m_pwrite,
  output logic [31:0]             m_pwdata,
  output logic [3:0]              m_pwstrb,
  input  logic [31:0]             m_prdata,
  input  logic                    m_pslverr,
  output logic [N_REQ-1:0]        grant
);

  localparam int PTR_W = ptr_width(N_REQ);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, next_ptr;
  logic [N_REQ-1:0] pick;
  logic             pick_valid;
  logic             done;

  rr_pick #(
    .N_REQ(N_REQ),
    .PTR_W(PTR_W)
  ) u_pick (
    .req   (r_psel),
    .ptr   (ptr_q),
    .mode  (ROUND_ROBIN != 0),
    .winner(pick),
    .valid (pick_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant   <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  // The requester after the completing owner gets first look next time.
  always_comb begin
    next_ptr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) next_ptr = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (pick_valid) begin
          grant_d = pick;
          state_d = SETUP;
        end
      end
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (m_pready) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_psel    = (state_q != IDLE);
  assign m_penable = (state_q == ACCESS);
  assign done      = m_penable & m_pready;

  // Transfer fields come straight from the owner's slices; grant is zero in IDLE.
  always_comb begin
    m_paddr  = '0;
    m_pwrite = 1'b0;
    m_pwdata = '0;
    m_pwstrb = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        m_paddr  = r_paddr[i*ADDR_W +: ADDR_W];
        m_pwrite = r_pwrite[i];
        m_pwdata = r_pwdata[i*32 +: 32];
        m_pwstrb = r_pwstrb[i*4 +: 4];
      end
    end
  end

  always_comb begin
    r_pready  = '0;
    r_prdata  = '0;
    r_pslverr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i] && done) begin
        r_pready[i]          = 1'b1;
        r_prdata[i*32 +: 32] = m_prdata;
        r_pslverr[i]         = m_pslverr;
      end
    end
  end

`ifndef SYNTHESIS
  // The owner must keep its request up and be in its own ACCESS phase until pready.
  granted_psel_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != IDLE) |-> |(r_psel & grant))
    else $error("granted requester dropped psel mid-transfer");

  granted_penable_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ACCESS) |-> |(r_penable & grant))
    else $error("granted requester not in ACCESS while arbiter in ACCESS");
`endif

endmodule
